// File: rtl/div_seq_param.sv
// Multicycle restoring divider (signed/unsigned) producing quotient on lo and remainder on hi.
// Latency WIDTH+2 edges after acceptance (divide-by-zero short-cuts to DONE); start is ignored while busy.
module div_seq_param #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             overflow,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ITER, S_FIX, S_DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] x_r, y_r, ymag, quo, rem;
  logic [CW-1:0]    cnt;
  logic             smode, neg_q, neg_r;

  // Sign extraction and magnitudes, only meaningful while in SETUP
  logic             sx, sy;
  logic [WIDTH-1:0] xmag, ymag_nxt;
  // One restoring step on the (WIDTH+1)-bit partial remainder
  logic [WIDTH:0]   rem_sh, trial;
  logic             trial_ok;

  always_comb begin
    sx       = smode & x_r[WIDTH-1];
    sy       = smode & y_r[WIDTH-1];
    xmag     = sx ? -x_r : x_r;
    ymag_nxt = sy ? -y_r : y_r;
    rem_sh   = {rem, quo[WIDTH-1]};
    trial    = rem_sh - {1'b0, ymag};
    trial_ok = ~trial[WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SETUP;
      S_SETUP: begin
        busy      = 1'b1;
        state_nxt = (y_r == '0) ? S_DONE : S_ITER;
      end
      S_ITER: begin
        busy = 1'b1;
        if (cnt == CNT_ONE) state_nxt = S_FIX;
      end
      S_FIX: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // lo/hi are loaded on the edge entering DONE so they are valid alongside done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_r      <= '0;
      y_r      <= '0;
      ymag     <= '0;
      quo      <= '0;
      rem      <= '0;
      cnt      <= '0;
      smode    <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      overflow <= 1'b0;
      lo       <= '0;
      hi       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            x_r      <= x;
            y_r      <= y;
            smode    <= signed_mode & SIGNED_EN;
            div_zero <= 1'b0;
            overflow <= 1'b0;
          end
        end
        S_SETUP: begin
          quo      <= xmag;
          ymag     <= ymag_nxt;
          rem      <= '0;
          cnt      <= CNT_INIT;
          neg_q    <= sx ^ sy;
          neg_r    <= sx;
          overflow <= smode && (x_r == MIN_VAL) && (y_r == '1);
          if (y_r == '0) begin
            div_zero <= 1'b1;
            lo       <= '1;
            hi       <= x_r;
          end
        end
        S_ITER: begin
          rem <= trial_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], trial_ok};
          cnt <= cnt - CNT_ONE;
        end
        S_FIX: begin
          lo <= neg_q ? -quo : quo;
          hi <= neg_r ? -rem : rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_param.sv
// Directed bench for div_seq_param: 32-bit signed-capable instance and an 8-bit unsigned-only instance.
module tb_div_seq_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, signed_mode;
  logic [31:0] x, y;
  logic        busy, done, div_zero, overflow;
  logic [31:0] lo, hi;

  logic        start8, signed_mode8;
  logic [7:0]  x8, y8;
  logic        busy8, done8, div_zero8, overflow8;
  logic [7:0]  lo8, hi8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  div_seq_param #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .x(x), .y(y), .busy(busy), .done(done), .div_zero(div_zero),
    .overflow(overflow), .lo(lo), .hi(hi)
  );

  div_seq_param #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .signed_mode(signed_mode8),
    .x(x8), .y(y8), .busy(busy8), .done(done8), .div_zero(div_zero8),
    .overflow(overflow8), .lo(lo8), .hi(hi8)
  );

  // Issue one operation; edges counts rising edges after the accepting edge until done is seen
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic sm,
                      output int edges, output logic busy0, output logic done_after);
    @(negedge clk);
    x = a; y = b; signed_mode = sm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy0 = busy;
    edges = 0;
    while (done !== 1'b1 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({busy, done, div_zero, overflow} !== 4'b0) begin
      n_bad++; $display("FAIL reset_flags got %b want 0000", {busy, done, div_zero, overflow});
    end
    n_cmp++;
    if (lo !== 32'h0 || hi !== 32'h0) begin
      n_bad++; $display("FAIL reset_lohi got lo=%h hi=%h want 0/0", lo, hi);
    end
  endtask

  task automatic test_unsigned();
    int e; logic b0, da;
    op32(32'd100, 32'd7, 1'b0, e, b0, da);
    n_cmp++;
    if (b0 !== 1'b1) begin n_bad++; $display("FAIL uns_busy_at_accept got %b want 1", b0); end
    n_cmp++;
    if (e !== 34) begin n_bad++; $display("FAIL uns_latency got %0d want 34", e); end
    n_cmp++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      n_bad++; $display("FAIL uns_result got lo=%0d hi=%0d want 14/2", lo, hi);
    end
    n_cmp++;
    if (div_zero !== 1'b0 || overflow !== 1'b0) begin
      n_bad++; $display("FAIL uns_flags got dz=%b ov=%b want 0/0", div_zero, overflow);
    end
    n_cmp++;
    if (da !== 1'b0) begin n_bad++; $display("FAIL uns_done_pulse got %b want 0", da); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (lo !== 32'd14 || hi !== 32'd2 || busy !== 1'b0) begin
      n_bad++; $display("FAIL uns_hold got lo=%0d hi=%0d busy=%b want 14/2/0", lo, hi, busy);
    end
  endtask

  task automatic test_signed();
    int e; logic b0, da;
    op32(32'hFFFF_FFF9, 32'd2, 1'b1, e, b0, da);
    n_cmp++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || e !== 34) begin
      n_bad++; $display("FAIL sgn_neg_dividend got lo=%h hi=%h edges=%0d want fffffffd/ffffffff/34", lo, hi, e);
    end
    op32(32'd7, 32'hFFFF_FFFE, 1'b1, e, b0, da);
    n_cmp++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin
      n_bad++; $display("FAIL sgn_neg_divisor got lo=%h hi=%h want fffffffd/00000001", lo, hi);
    end
    n_cmp++;
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL sgn_no_ovf got %b want 0", overflow); end
  endtask

  task automatic test_div_zero();
    int e; logic b0, da;
    op32(32'h1234, 32'h0, 1'b0, e, b0, da);
    // Two edges counting the accepting edge: SETUP then straight to DONE
    n_cmp++;
    if (e !== 1) begin n_bad++; $display("FAIL dz_latency got %0d want 1", e); end
    n_cmp++;
    if (div_zero !== 1'b1 || lo !== 32'hFFFF_FFFF || hi !== 32'h1234) begin
      n_bad++; $display("FAIL dz_result got dz=%b lo=%h hi=%h want 1/ffffffff/00001234", div_zero, lo, hi);
    end
    @(negedge clk);
    x = 32'd9; y = 32'd3; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (div_zero !== 1'b0) begin n_bad++; $display("FAIL dz_clear_at_accept got %b want 0", div_zero); end
    e = 0;
    while (done !== 1'b1 && e < 100) begin @(posedge clk); #1; e++; end
    n_cmp++;
    if (lo !== 32'd3 || hi !== 32'd0 || e !== 34) begin
      n_bad++; $display("FAIL dz_followup got lo=%0d hi=%0d edges=%0d want 3/0/34", lo, hi, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    int e; logic b0, da;
    op32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, e, b0, da);
    n_cmp++;
    if (overflow !== 1'b1 || lo !== 32'h8000_0000 || hi !== 32'h0) begin
      n_bad++; $display("FAIL ovf_signed got ov=%b lo=%h hi=%h want 1/80000000/0", overflow, lo, hi);
    end
    op32(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, e, b0, da);
    n_cmp++;
    if (overflow !== 1'b0 || lo !== 32'h0 || hi !== 32'h8000_0000) begin
      n_bad++; $display("FAIL ovf_unsigned got ov=%b lo=%h hi=%h want 0/0/80000000", overflow, lo, hi);
    end
  endtask

  task automatic test_reset_mid_op();
    int e, dones; logic b0, da;
    @(negedge clk);
    x = 32'd1000; y = 32'd9; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, div_zero, overflow} !== 4'b0 || lo !== 32'h0 || hi !== 32'h0) begin
      n_bad++; $display("FAIL rst_mid_async got busy=%b done=%b lo=%h hi=%h want all 0", busy, done, lo, hi);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    dones = 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) dones++; end
    n_cmp++;
    if (dones !== 0) begin n_bad++; $display("FAIL rst_mid_no_done got %0d dones want 0", dones); end
    op32(32'd1000, 32'd9, 1'b0, e, b0, da);
    n_cmp++;
    if (lo !== 32'd111 || hi !== 32'd1 || e !== 34) begin
      n_bad++; $display("FAIL rst_reissue got lo=%0d hi=%0d edges=%0d want 111/1/34", lo, hi, e);
    end
  endtask

  task automatic test_start_during_busy();
    int e;
    @(negedge clk);
    x = 32'd100; y = 32'd7; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    x = 32'd50; y = 32'd5; signed_mode = 1'b1;
    e = 0;
    // start stays high and operands change throughout the operation
    while (done !== 1'b1 && e < 100) begin
      @(posedge clk); #1; e++;
      if (e == 5) begin x = 32'hFFFF_FF00; y = 32'h0; end
    end
    start = 1'b0;
    n_cmp++;
    if (lo !== 32'd14 || hi !== 32'd2 || e !== 34) begin
      n_bad++; $display("FAIL busy_ignore got lo=%0d hi=%0d edges=%0d want 14/2/34", lo, hi, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_width8_unsigned_only();
    int e;
    @(negedge clk);
    x8 = 8'd200; y8 = 8'd3; signed_mode8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    e = 0;
    while (done8 !== 1'b1 && e < 100) begin @(posedge clk); #1; e++; end
    n_cmp++;
    if (e !== 10) begin n_bad++; $display("FAIL w8_latency got %0d want 10", e); end
    n_cmp++;
    if (lo8 !== 8'd66 || hi8 !== 8'd2 || overflow8 !== 1'b0) begin
      n_bad++; $display("FAIL w8_result got lo=%0d hi=%0d ov=%b want 66/2/0", lo8, hi8, overflow8);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; x = '0; y = '0;
    start8 = 1'b0; signed_mode8 = 1'b0; x8 = '0; y8 = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk) reset = 1'b0;
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_reset_mid_op();
    test_start_during_busy();
    test_width8_unsigned_only();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_seq_param.md
Name: div_seq_param

Overview:
- Parametrised multicycle integer divider for the multicycle processor datapath.
- Successor of the fixed 32-bit divider. Adds:
  - configurable width;
  - signed/unsigned selection per operation;
  - a remainder output;
  - start/busy/done handshake;
  - divide-by-zero and signed-overflow flags.
- Sits beside the ALU; the control unit issues start and stalls on busy until done.
- lo receives the quotient and hi the remainder, matching the processor's lo/hi registers.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- SIGNED_EN, 1, when 0 signed_mode is ignored and all operations are unsigned.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  operation request, sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement division, 0 = unsigned; sampled with start.
- x  in  WIDTH  dividend, sampled with start.
- y  in  WIDTH  divisor, sampled with start.
- busy  out  1  high from the accepting edge until done rises.
- done  out  1  single-cycle pulse; results valid.
- div_zero  out  1  last operation had y == 0.
- overflow  out  1  last operation was signed MIN / -1.
- lo  out  WIDTH  quotient.
- hi  out  WIDTH  remainder.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE.
  - busy, done, div_zero, overflow = 0; lo, hi = 0.
  - Internal operand, quotient, remainder and counter registers = 0.
  - The in-flight operation is discarded; no done is produced.
- States: IDLE, SETUP, ITER, FIX, DONE.
- IDLE: start=1 latches x, y, and effective signed mode (signed_mode & SIGNED_EN). Next state SETUP; busy=1; div_zero and overflow are cleared.
- SETUP (1 cycle):
  - Sign of each operand = MSB when signed, else 0.
  - Magnitudes are formed by two's-complement negation of negative operands.
  - neg_q = sx ^ sy; neg_r = sx.
  - Counter = WIDTH.
  - If y == 0 -> DONE directly, no iterations.
  - Else -> ITER.
- ITER (exactly WIDTH cycles), restoring shift-subtract over a (WIDTH+1)-bit partial remainder:
  - Shift {rem, quo} left by 1, bringing in the next dividend bit MSB-first.
  - Trial subtract |y|. If non-negative: keep the difference and set quotient bit = 1. Else restore and set quotient bit = 0.
  - Counter decrements; at counter==1 the next state is FIX.
- FIX (1 cycle):
  - Quotient is negated if neg_q; remainder is negated if neg_r.
  - Signed rounding truncates toward zero; the remainder takes the dividend's sign; |hi| < |y|.
- DONE (1 cycle):
  - Registers lo/hi (and flags); done=1 and busy=0 in the same cycle.
  - Next state IDLE.
  - start is not accepted in DONE, only in IDLE on the following cycle.
- Latency:
  - Normal: done is high in the cycle after the (WIDTH+2)th rising edge following the accepting edge, i.e. 34 edges for WIDTH=32.
  - Divide-by-zero: done after 2 edges.
- Divide by zero: div_zero=1; lo = all ones; hi = x (unmodified dividend), in both modes.
- Signed overflow (signed, x = 100..0, y = all ones): overflow=1; lo = x; hi = 0. The iteration path produces these values naturally; the flag is set in SETUP.
- Unsigned mode never raises overflow.
- Output hold: lo, hi, div_zero and overflow hold until the next accepted start (the flags clear at acceptance; lo/hi update only in DONE).
- start while not in IDLE is ignored. It is not queued, and x, y and signed_mode changes mid-operation have no effect.
- All arithmetic uses explicit unsigned vectors; sign handling is done only in SETUP and FIX.

Test Plan:
- Unsigned, WIDTH=32: start with x=100, y=7, signed_mode=0 -> busy for 34 edges; done pulse 1 cycle; lo=14, hi=2; flags=0.
- Signed: x=-7 (0xFFFFFFF9), y=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also x=7, y=-2 -> lo=-3, hi=1.
- Divide by zero: x=0x1234, y=0 -> done after 2 edges; div_zero=1; lo=0xFFFFFFFF; hi=0x1234. Next start with y=3 clears div_zero at acceptance.
- Signed overflow: x=0x80000000, y=0xFFFFFFFF, signed -> overflow=1, lo=0x80000000, hi=0. The same operands in unsigned mode -> lo=0, hi=0x80000000, overflow=0.
- Robustness:
  - Assert reset 10 cycles into an operation: all outputs 0 immediately (async), no done.
  - Re-issue after reset completes correctly.
  - start pulses during busy are ignored and the results match the first operands.
- WIDTH=8, SIGNED_EN=0 instance: x=200, y=3, signed_mode=1 -> treated as unsigned; lo=66, hi=2; done after 10 edges.
